// File: rtl/fifo_uart_tx_pkg.sv
// +----------------------------------------------------------------------+
// | fifo_uart_tx_pkg : shared UART state encoding and default constants  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package fifo_uart_tx_pkg;

  localparam int c_dbit_default    = 8;
  localparam int c_sb_tick_default = 16;
  localparam int c_dvsr_default    = 163;
  localparam int c_dvsr_w_default  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Width able to hold 0..v-1, never narrower than one bit.
  function automatic int clog2_safe(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_uart_tx_baud_gen.sv
// +----------------------------------------------------------------------+
// | baud_gen : free-running mod-M counter, max_tick pulses at count M-1   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module baud_gen #(
  parameter int M = 163,
  parameter int N = 8
) (
  input  logic clk,
  input  logic reset,
  output logic max_tick
);

  logic [N-1:0] r_count;
  logic         w_at_max;

  assign w_at_max = (r_count == N'(M - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_count <= '0;
    else if (w_at_max)
      r_count <= '0;
    else
      r_count <= r_count + 1'b1;
  end

  assign max_tick = w_at_max;

endmodule

`default_nettype wire

// File: rtl/fifo_uart_tx.sv
// +----------------------------------------------------------------------+
// | fifo_uart_tx : UART transmitter draining a first-word-fall-through   |
// | FIFO, one pop per frame.  Revision: 1.0                              |
// +----------------------------------------------------------------------+
`default_nettype none

module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DBIT    = c_dbit_default,
  parameter int SB_TICK = c_sb_tick_default,
  parameter int DVSR    = c_dvsr_default,
  parameter int DVSR_W  = c_dvsr_w_default
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_r_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy
);

  localparam int c_tick_max = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int c_tick_w   = clog2_safe(c_tick_max);
  localparam int c_bit_w    = clog2_safe(DBIT);

  tx_state_t             r_state, w_state_next;
  logic [c_tick_w-1:0]   r_tick, w_tick_next;
  logic [c_bit_w-1:0]    r_bit, w_bit_next;
  logic [DBIT-1:0]       r_shift, w_shift_next;
  logic                  r_tx, w_tx_next;
  logic                  w_rd;
  logic                  w_s_tick;

  baud_gen #(
    .M (DVSR),
    .N (DVSR_W)
  ) u_baud_gen (
    .clk      (clk),
    .reset    (reset),
    .max_tick (w_s_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_tick  <= w_tick_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tick_next  = r_tick;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_rd         = 1'b0;
    w_tx_next    = 1'b1;
    case (r_state)
      IDLE: begin
        if (!fifo_empty) begin
          w_shift_next = fifo_r_data;
          w_rd         = 1'b1;
          w_tick_next  = '0;
          w_state_next = START;
        end
      end
      START: begin
        if (w_s_tick) begin
          if (r_tick == c_tick_w'(15)) begin
            w_tick_next  = '0;
            w_bit_next   = '0;
            w_state_next = DATA;
          end else begin
            w_tick_next = r_tick + 1'b1;
          end
        end
      end
      DATA: begin
        if (w_s_tick) begin
          if (r_tick == c_tick_w'(15)) begin
            w_tick_next  = '0;
            w_shift_next = r_shift >> 1;
            if (r_bit == c_bit_w'(DBIT - 1))
              w_state_next = STOP;
            else
              w_bit_next = r_bit + 1'b1;
          end else begin
            w_tick_next = r_tick + 1'b1;
          end
        end
      end
      STOP: begin
        if (w_s_tick) begin
          if (r_tick == c_tick_w'(SB_TICK - 1))
            w_state_next = IDLE;
          else
            w_tick_next = r_tick + 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
    // The line level is registered from the upcoming state so tx lines up with r_state.
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  // The pop is masked during reset so a non-empty FIFO is never drained while held.
  assign fifo_rd = w_rd & ~reset;
  assign tx      = r_tx;
  assign tx_busy = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
// +----------------------------------------------------------------------+
// | tb_fifo_uart_tx : directed self-checking bench, DVSR=2 (32 clk/bit)  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo_empty, fifo_empty2;
  logic [7:0] fifo_r_data, fifo_r_data2;
  logic       fifo_rd, fifo_rd2;
  logic       tx, tx2;
  logic       tx_busy, tx_busy2;

  int cmp  = 0;
  int mism = 0;
  int pops = 0;
  int pops2 = 0;
  int rd_empty_viol = 0;
  int rd_in_reset = 0;

  logic [7:0] q[$];
  logic [7:0] q2[$];
  logic s_tx, s_busy, s_rd, s_tx2, s_rd2;
  logic lg_tx[0:799];
  logic lg_busy[0:799];
  logic lg_tx2[0:799];

  always #5 clk = ~clk;

  fifo_uart_tx #(.DBIT(8), .SB_TICK(16), .DVSR(2), .DVSR_W(8)) u_dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_r_data(fifo_r_data),
    .fifo_rd(fifo_rd), .tx(tx), .tx_busy(tx_busy)
  );

  fifo_uart_tx #(.DBIT(8), .SB_TICK(32), .DVSR(2), .DVSR_W(8)) u_dut_sb32 (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty2), .fifo_r_data(fifo_r_data2),
    .fifo_rd(fifo_rd2), .tx(tx2), .tx_busy(tx_busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, then model the FIFO pop just after the edge.
  task automatic cyc();
    @(negedge clk);
    s_tx = tx; s_busy = tx_busy; s_rd = fifo_rd; s_tx2 = tx2; s_rd2 = fifo_rd2;
    if (fifo_rd && fifo_empty) rd_empty_viol++;
    if (fifo_rd2 && fifo_empty2) rd_empty_viol++;
    if (reset && (fifo_rd || fifo_rd2)) rd_in_reset++;
    @(posedge clk);
    #1;
    if (s_rd) begin
      pops++;
      if (q.size() > 0) void'(q.pop_front());
      fifo_empty = (q.size() == 0);
      if (q.size() > 0) fifo_r_data = q[0];
    end
    if (s_rd2) begin
      pops2++;
      if (q2.size() > 0) void'(q2.pop_front());
      fifo_empty2 = (q2.size() == 0);
      if (q2.size() > 0) fifo_r_data2 = q2[0];
    end
  endtask

  task automatic push(input logic [7:0] w);
    q.push_back(w);
    fifo_empty = 1'b0;
    fifo_r_data = q[0];
  endtask

  task automatic push2(input logic [7:0] w);
    q2.push_back(w);
    fifo_empty2 = 1'b0;
    fifo_r_data2 = q2[0];
  endtask

  task automatic wait_pop(input int which, input string tag, output int n);
    n = 0;
    cyc();
    while (((which == 1) ? s_rd : s_rd2) !== 1'b1 && n < 1000) begin
      cyc();
      n++;
    end
    chk(tag, 32'(((which == 1) ? s_rd : s_rd2) === 1'b1), 32'd1);
  endtask

  // Index 0 of the log is the first START cycle.
  task automatic capture(input int len, input bit corrupt);
    for (int i = 0; i < len; i++) begin
      cyc();
      lg_tx[i] = s_tx; lg_busy[i] = s_busy; lg_tx2[i] = s_tx2;
      if (corrupt && i == 0) fifo_r_data = 8'h3C;
    end
  endtask

  // Mid-bit samples: start 0, data LSB first, stop 1.
  task automatic check_frame(input int base, input logic [7:0] b, input string tag);
    logic e;
    for (int k = 0; k < 10; k++) begin
      e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      chk($sformatf("%s_bit%0d", tag, k), 32'(lg_tx[base + 16 + 32*k]), 32'(e));
    end
  endtask

  initial begin
    int n, p0, bc, s2, h, run, bad_tx, bad_rd, bad_busy;
    reset = 1'b1; fifo_empty = 1'b1; fifo_r_data = 8'h00;
    fifo_empty2 = 1'b1; fifo_r_data2 = 8'h00;
    cyc(); cyc();
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_rd", 32'(fifo_rd), 32'd0);
    reset = 1'b0;

    // Idle line with an empty FIFO.
    bad_tx = 0; bad_rd = 0; bad_busy = 0;
    for (int i = 0; i < 2000; i++) begin
      cyc();
      if (s_tx !== 1'b1) bad_tx++;
      if (s_rd !== 1'b0) bad_rd++;
      if (s_busy !== 1'b0) bad_busy++;
    end
    chk("idle_tx_bad", bad_tx, 0);
    chk("idle_rd_bad", bad_rd, 0);
    chk("idle_busy_bad", bad_busy, 0);

    // Single 0xA5 frame.
    p0 = pops;
    push(8'hA5);
    wait_pop(1, "a5_pop", n);
    capture(340, 1'b0);
    check_frame(0, 8'hA5, "a5");
    bc = 0;
    for (int i = 0; i < 340; i++) if (lg_busy[i] === 1'b1) bc++;
    chk("a5_busy_len_319_320", 32'(bc >= 319 && bc <= 320), 32'd1);
    chk("a5_pop_count", pops - p0, 1);

    // Two queued words sent back to back.
    p0 = pops;
    push(8'h00); push(8'hFF);
    wait_pop(1, "pair_pop", n);
    capture(700, 1'b0);
    check_frame(0, 8'h00, "w00");
    s2 = 320;
    for (int i = 380; i >= 300; i--) if (lg_tx[i] === 1'b0) s2 = i;
    chk("pair_second_start_320_321", 32'(s2 >= 320 && s2 <= 321), 32'd1);
    check_frame(s2, 8'hFF, "wFF");
    chk("pair_pop_count", pops - p0, 2);

    // Head word changes right after the pop.
    push(8'h81);
    wait_pop(1, "w81_pop", n);
    capture(340, 1'b1);
    check_frame(0, 8'h81, "w81");

    // Reset in the middle of DATA (bit 1 of 0x55 is low).
    push(8'h55); push(8'h0F);
    wait_pop(1, "w55_pop", n);
    p0 = pops;
    capture(79, 1'b0);
    @(negedge clk);
    chk("pre_rst_tx", 32'(tx), 32'd0);
    chk("pre_rst_busy", 32'(tx_busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_tx", 32'(tx), 32'd1);
    chk("async_rst_busy", 32'(tx_busy), 32'd0);
    chk("async_rst_rd", 32'(fifo_rd), 32'd0);
    cyc(); cyc(); cyc();
    chk("rd_during_reset", rd_in_reset, 0);
    chk("rst_pop_count", pops - p0, 0);
    reset = 1'b0;
    #1;
    chk("release_rd", 32'(fifo_rd), 32'd1);
    wait_pop(1, "w0F_pop", n);
    chk("release_first_edge", n, 0);
    capture(340, 1'b0);
    check_frame(0, 8'h0F, "w0F");
    chk("release_pop_count", pops - p0, 1);
    chk("release_fifo_empty", 32'(fifo_empty), 32'd1);

    // 2-stop-bit build: high run between frames.
    p0 = pops2;
    push2(8'h00); push2(8'h00);
    wait_pop(2, "sb32_pop", n);
    capture(700, 1'b0);
    h = 0;
    for (int i = 399; i >= 200; i--) if (lg_tx2[i] === 1'b1) h = i;
    s2 = h + 700;
    for (int i = 699; i > h; i--) if (lg_tx2[i] === 1'b0) s2 = i;
    run = s2 - h;
    chk("sb32_stop_run_64_65", 32'(run >= 64 && run <= 65), 32'd1);
    chk("sb32_pop_count", pops2 - p0, 2);

    chk("rd_while_empty", rd_empty_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end

endmodule

`default_nettype wire
